instr_prefetch_queue: RTL and testbench
=======================================

// Module: instr_prefetch_queue
// PURPOSE
// Fetch front-end upstream of the IF/ID pipeline register: generates sequential PCs, issues
// requests to a 1-cycle-latency instruction memory, and buffers {pc+4, instruction} pairs
// in a small FIFO. It decouples fetch from ID-stage stalls (IF/ID write low) and discards
// wrong-path fetches on a branch/jump redirect.
// PARAMETERS
// DEPTH    4            queue entries; power of two, >= 2
// RESET_PC 32'h0000_0000 first fetch address after reset
// PORTS
// clk           in   1   clock; all state updates on rising edge
// reset         in   1   asynchronous, active-low reset
// imem_req      out  1   instruction-memory read request this cycle
// imem_addr     out  32  word-aligned fetch address (valid when imem_req=1)
// imem_rvalid   in   1   read data valid; asserted exactly 1 cycle after an accepted imem_req
// imem_rdata    in   32  instruction word returned
// redirect      in   1   branch taken / jump from ID stage (IF flush)
// redirect_pc   in   32  target address for redirect
// if_ready      in   1   IF/ID register write enable (consumer accepts head entry)
// if_valid      out  1   head entry valid
// if_instr      out  32  head instruction; 32'h0 when if_valid=0
// if_pcplus4    out  32  head entry PC+4
// BEHAVIOUR
// - Reset (reset=0, any time, async): fetch_pc<=RESET_PC, queue empty, in-flight flag clear,
//   drop flag clear; outputs imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0,
//   if_pcplus4=0. Pending memory response arriving after reset release is ignored.
// - Credit rule: imem_req=1 iff !redirect && (count + inflight) < DEPTH. inflight is 0/1
//   (one outstanding request per cycle, 1-cycle latency). Queue therefore never overflows.
// - On issue: imem_addr=fetch_pc; fetch_pc<=fetch_pc+4 (32-bit modulo wrap, 0xFFFF_FFFC->0).
// - On imem_rvalid && !drop: push {fetch address+4, imem_rdata} at tail.
// - Pop when if_valid && if_ready; head advances. Push and pop in same cycle allowed at any
//   occupancy including full (count unchanged) and empty-with-push (no bypass: entry
//   visible next cycle).
// - if_valid = (count!=0); if_instr/if_pcplus4 read combinationally from head slot.
// - Redirect (highest priority over push/pop/issue): queue cleared (count=0, ptrs=0),
//   fetch_pc<=redirect_pc, no request issued that cycle; if a request is in flight its
//   response next cycle is dropped (drop<=1, cleared after that cycle). Pop in redirect
//   cycle is still honoured by consumer (entry leaves), but queue content is discarded.
// - Redirect latency: redirect at T -> imem_req for redirect_pc at T+1 -> imem_rvalid T+2
//   -> if_valid=1 with target instr at T+3.
// - Back-to-back redirects: each overrides the last; only final redirect_pc fetched.
// - Steady state with if_ready=1: one instruction per cycle after 2-cycle fill.
// - redirect_pc[1:0] ignored (forced 2'b00).
// TESTING
// 1 Reset release, RESET_PC=0, if_ready=1, imem returns 0x20080001.. -> imem_addr 0,4,8..
//   one per cycle; if_valid first high cycle 3; if_pcplus4=4,8,12 in order.
// 2 if_ready=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req=0 once
//   count+inflight=4; release -> 4 entries drain in order, fetch resumes without gap/dup.
// 3 redirect=1, redirect_pc=0x40 while request to 0x10 in flight -> 0x10 response dropped,
//   queue empty next cycle, next imem_addr=0x40, first if_pcplus4=0x44.
// 4 Queue full, push+pop same cycle repeatedly -> count stays 4, order preserved, no loss.
// 5 Assert reset mid-stream (queue 3 deep, request in flight) -> all outputs to reset
//   values immediately; after release first fetch at RESET_PC, stale response ignored.
// 6 redirect_pc=0xFFFF_FFFC -> next fetches 0xFFFF_FFFC then 0x0000_0000 (wrap).

Source files
------------

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential-PC fetch front-end buffering {pc+4, instr} pairs for the IF/ID stage
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pcplus4
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          inflight_q, drop_q, push, pop;
  logic [31:0]   fetch_pc_q, req_addr_q;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pcp4_mem  [DEPTH];
  // Credits cover both stored entries and the one response still on its way, so a push always has room.
  assign imem_req   = reset && !redirect && (int'(count_q) + int'(inflight_q) < DEPTH);
  assign imem_addr  = fetch_pc_q;
  assign if_valid   = count_q != '0;
  assign push       = imem_rvalid && inflight_q && !drop_q;
  assign pop        = if_valid && if_ready;
  assign if_instr   = if_valid ? instr_mem[rd_ptr_q] : '0;
  assign if_pcplus4 = if_valid ? pcp4_mem[rd_ptr_q] : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else if (redirect) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= inflight_q;
      inflight_q <= 1'b0;
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
    end else begin
      wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_q    <= count_q + CW'(push) - CW'(pop);
      drop_q     <= 1'b0;
      inflight_q <= imem_req;
      fetch_pc_q <= imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q;
      req_addr_q <= imem_req ? fetch_pc_q : req_addr_q;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !redirect) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pcp4_mem[wr_ptr_q]  <= req_addr_q + 32'd4;
    end
  end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: random and directed stimulus against a queue-based reference of the fetch front-end
module tb_instr_prefetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, if_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_instr, if_pcplus4;
  int          checks = 0, failures = 0;
  logic [63:0] q[$];
  logic [31:0] fpc = RESET_PC, pend_addr = '0, mem_addr_prev = '0;
  bit          pend = 0, mem_req_prev = 0, stale = 0;
  instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .if_ready(if_ready), .if_valid(if_valid),
    .if_instr(if_instr), .if_pcplus4(if_pcplus4)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ifn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2008_0001;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask
  // One clock cycle: drive inputs at the falling edge, check outputs, then advance the reference.
  task automatic cyc(input bit rd, input logic [31:0] rp, input bit rdy, input bit rn);
    bit ereq, ev;
    @(negedge clk);
    reset = rn;
    redirect = rd;
    redirect_pc = rp;
    if_ready = rdy;
    imem_rvalid = mem_req_prev || stale;
    imem_rdata = stale ? 32'hDEAD_BEEF : ifn(mem_addr_prev);
    stale = 0;
    if (!rn) begin
      q.delete();
      fpc = RESET_PC;
      pend = 0;
    end
    #1;
    ev = rn && q.size() != 0;
    ereq = rn && !rd && (q.size() + int'(pend) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(ereq));
    chk("imem_addr", imem_addr, fpc);
    chk("if_valid", 32'(if_valid), 32'(ev));
    chk("if_instr", if_instr, ev ? q[0][31:0] : 32'h0);
    chk("if_pcplus4", if_pcplus4, ev ? q[0][63:32] : 32'h0);
    mem_req_prev = imem_req;
    mem_addr_prev = imem_addr;
    if (!rn) return;
    if (rd) begin
      q.delete();
      fpc = {rp[31:2], 2'b00};
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (pend) q.push_back({pend_addr + 32'd4, ifn(pend_addr)});
      if (ereq) begin
        pend_addr = fpc;
        fpc = fpc + 32'd4;
      end
    end
    pend = ereq;
  endtask
  initial begin
    repeat (3) cyc(0, '0, 1, 0);
    stale = 1;
    repeat (12) cyc(0, '0, 1, 1);
    repeat (10) cyc(0, '0, 0, 1);
    repeat (10) cyc(0, '0, 1, 1);
    cyc(1, 32'h0000_0041, 1, 1);
    repeat (6) cyc(0, '0, 1, 1);
    repeat (5) cyc(0, '0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, '0, i[0], 1);
    cyc(1, 32'h1000_0000, 1, 1);
    cyc(1, 32'hFFFF_FFFC, 0, 1);
    repeat (6) cyc(0, '0, 1, 1);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 1);
    repeat (2) cyc(0, '0, 1, 0);
    stale = 1;
    repeat (6) cyc(0, '0, 1, 1);
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 99) != 0);
      if (!reset && $urandom_range(0, 1) == 1) stale = 1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
